// File: rtl/avl_sched_pkg.sv
// Shared types and widths for the Avalon port scheduler.
package avl_sched_pkg;

  localparam int WORD_ADDR_W = 25;
  localparam int AVL_ADDR_W  = 26;
  localparam int DATA_W      = 16;
  localparam int STAT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WR,
    REQ_V,
    REQ_A
  } req_id_e;

  // The bridge is byte addressed over 16-bit words.
  function automatic logic [AVL_ADDR_W-1:0] to_byte_addr(input logic [WORD_ADDR_W-1:0] word_addr);
    return {word_addr, 1'b0};
  endfunction

endpackage

// File: rtl/avl_sched_starve_ctr.sv
// Audio starvation counter: counts waiting cycles, saturates at LIMIT, clears on audio grant.
module avl_sched_starve_ctr #(
  parameter int LIMIT = 64
) (
  input  logic MAX10_CLK1_50,
  input  logic Reset_h,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);

  localparam int            CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIM))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign starved_o = (cnt_q >= LIM);

endmodule

// File: rtl/avl_port_scheduler.sv
// Arbitrates SD-loader writes, video reads and audio reads onto one Avalon bridge master.
// Optional grant statistics counters are built when AVL_SCHED_STATS_EN is defined.
module avl_port_scheduler
  import avl_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   Reset_h,
  input  logic                   wr_override,
  input  logic                   wr_req,
  input  logic [WORD_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ack,
  input  logic                   v_req,
  input  logic [WORD_ADDR_W-1:0] v_addr,
  output logic                   v_ack,
  output logic [DATA_W-1:0]      v_data,
  input  logic                   a_req,
  input  logic [WORD_ADDR_W-1:0] a_addr,
  output logic                   a_ack,
  output logic [DATA_W-1:0]      a_data,
  output logic [AVL_ADDR_W-1:0]  avl_addr,
  output logic                   avl_read,
  output logic                   avl_write,
  output logic [DATA_W-1:0]      avl_wdata,
  input  logic [DATA_W-1:0]      avl_rddata,
  input  logic                   avl_ack,
  output logic                   timeout_err,
  output logic [STAT_W-1:0]      stat_wr,
  output logic [STAT_W-1:0]      stat_v,
  output logic [STAT_W-1:0]      stat_a
);

  localparam int             TCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  state_e                  state_q;
  req_id_e                 gnt_q;
  req_id_e                 gnt_sel;
  logic [WORD_ADDR_W-1:0]  gnt_addr;
  logic [AVL_ADDR_W-1:0]   avl_addr_q;
  logic                    avl_read_q, avl_write_q;
  logic [DATA_W-1:0]       avl_wdata_q;
  logic                    wr_ack_q, v_ack_q, a_ack_q;
  logic [DATA_W-1:0]       v_data_q, a_data_q;
  logic                    last_a_q;
  logic [TCW-1:0]          to_cnt_q;
  logic                    timeout_err_q;
  logic                    starved;
  logic                    do_grant, a_grant, starve_inc;
  logic                    resp_done;
  logic [DATA_W-1:0]       resp_data;

  // Grant selection; only meaningful while IDLE.
  always_comb begin
    gnt_sel = REQ_NONE;
    if (wr_override) begin
      if (wr_req) gnt_sel = REQ_WR;
    end else if (a_req && starved) begin
      gnt_sel = REQ_A;
    end else if (v_req && a_req) begin
      gnt_sel = last_a_q ? REQ_V : REQ_A;
    end else if (v_req) begin
      gnt_sel = REQ_V;
    end else if (a_req) begin
      gnt_sel = REQ_A;
    end else if (wr_req) begin
      gnt_sel = REQ_WR;
    end
  end

  always_comb begin
    case (gnt_sel)
      REQ_V:   gnt_addr = v_addr;
      REQ_A:   gnt_addr = a_addr;
      default: gnt_addr = wr_addr;
    endcase
  end

  assign do_grant   = (state_q == ST_IDLE) && (gnt_sel != REQ_NONE);
  assign a_grant    = do_grant && (gnt_sel == REQ_A);
  // Audio's own transaction is not waiting time.
  assign starve_inc = a_req && !a_grant && (gnt_q != REQ_A);

  avl_sched_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .Reset_h       (Reset_h),
    .inc_i         (starve_inc),
    .clr_i         (a_grant),
    .starved_o     (starved)
  );

  // A timeout completes like an ack but returns zero data.
  assign resp_done = avl_ack || (to_cnt_q == TO_LAST);
  assign resp_data = avl_ack ? avl_rddata : '0;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state_q       <= ST_IDLE;
      gnt_q         <= REQ_NONE;
      avl_addr_q    <= '0;
      avl_read_q    <= 1'b0;
      avl_write_q   <= 1'b0;
      avl_wdata_q   <= '0;
      wr_ack_q      <= 1'b0;
      v_ack_q       <= 1'b0;
      a_ack_q       <= 1'b0;
      v_data_q      <= '0;
      a_data_q      <= '0;
      last_a_q      <= 1'b1;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      v_ack_q  <= 1'b0;
      a_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (do_grant) begin
            gnt_q       <= gnt_sel;
            avl_addr_q  <= to_byte_addr(gnt_addr);
            avl_read_q  <= (gnt_sel != REQ_WR);
            avl_write_q <= (gnt_sel == REQ_WR);
            avl_wdata_q <= (gnt_sel == REQ_WR) ? wr_data : '0;
            to_cnt_q    <= '0;
            if (gnt_sel == REQ_V) last_a_q <= 1'b0;
            if (gnt_sel == REQ_A) last_a_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (resp_done) begin
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
            case (gnt_q)
              REQ_WR: wr_ack_q <= 1'b1;
              REQ_V: begin
                v_ack_q  <= 1'b1;
                v_data_q <= resp_data;
              end
              REQ_A: begin
                a_ack_q  <= 1'b1;
                a_data_q <= resp_data;
              end
              default: ;
            endcase
            if (!avl_ack) timeout_err_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TCW'(1);
          end
        end
        ST_RESP: begin
          gnt_q   <= REQ_NONE;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avl_addr    = avl_addr_q;
  assign avl_read    = avl_read_q;
  assign avl_write   = avl_write_q;
  assign avl_wdata   = avl_wdata_q;
  assign wr_ack      = wr_ack_q;
  assign v_ack       = v_ack_q;
  assign a_ack       = a_ack_q;
  assign v_data      = v_data_q;
  assign a_data      = a_data_q;
  assign timeout_err = timeout_err_q;

`ifdef AVL_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_wr_q, stat_v_q, stat_a_q;

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      stat_wr_q <= '0;
      stat_v_q  <= '0;
      stat_a_q  <= '0;
    end else if (do_grant) begin
      case (gnt_sel)
        REQ_WR:  if (stat_wr_q != '1) stat_wr_q <= stat_wr_q + STAT_W'(1);
        REQ_V:   if (stat_v_q  != '1) stat_v_q  <= stat_v_q  + STAT_W'(1);
        REQ_A:   if (stat_a_q  != '1) stat_a_q  <= stat_a_q  + STAT_W'(1);
        default: ;
      endcase
    end
  end

  assign stat_wr = stat_wr_q;
  assign stat_v  = stat_v_q;
  assign stat_a  = stat_a_q;
`else
  assign stat_wr = '0;
  assign stat_v  = '0;
  assign stat_a  = '0;
`endif

endmodule

// File: tb/tb_avl_port_scheduler.sv
// Directed bench for avl_port_scheduler with a small Avalon bridge responder.
module tb_avl_port_scheduler;

  logic        clk;
  logic        Reset_h;
  logic        wr_override, wr_req, v_req, a_req;
  logic [24:0] wr_addr, v_addr, a_addr;
  logic [15:0] wr_data;
  logic        wr_ack, v_ack, a_ack;
  logic [15:0] v_data, a_data;
  logic [25:0] avl_addr;
  logic        avl_read, avl_write;
  logic [15:0] avl_wdata, avl_rddata;
  logic        avl_ack;
  logic        timeout_err;
  logic [15:0] stat_wr, stat_v, stat_a;

  int n_checks = 0;
  int n_pass   = 0;
  int br_lat   = 1;
  bit br_never = 0;
  int br_cnt   = 0;

  avl_port_scheduler #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .MAX10_CLK1_50 (clk),
    .Reset_h       (Reset_h),
    .wr_override   (wr_override),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .v_req         (v_req),
    .v_addr        (v_addr),
    .v_ack         (v_ack),
    .v_data        (v_data),
    .a_req         (a_req),
    .a_addr        (a_addr),
    .a_ack         (a_ack),
    .a_data        (a_data),
    .avl_addr      (avl_addr),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_wdata     (avl_wdata),
    .avl_rddata    (avl_rddata),
    .avl_ack       (avl_ack),
    .timeout_err   (timeout_err),
    .stat_wr       (stat_wr),
    .stat_v        (stat_v),
    .stat_a        (stat_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bridge: acks on the br_lat-th cycle of a strobe; read data = word address ^ 16'hA5A5.
  always @(negedge clk) begin
    if (Reset_h || !(avl_read || avl_write)) begin
      br_cnt     = 0;
      avl_ack    = 1'b0;
      avl_rddata = 16'hDEAD;
    end else begin
      br_cnt     = br_cnt + 1;
      avl_ack    = !br_never && (br_cnt == br_lat);
      avl_rddata = avl_ack ? (avl_addr[16:1] ^ 16'hA5A5) : 16'hDEAD;
    end
  end

  task automatic test_reset();
    Reset_h = 1'b1; wr_override = 0; wr_req = 0; v_req = 0; a_req = 0;
    wr_addr = '0; v_addr = '0; a_addr = '0; wr_data = '0;
    #1;
    n_checks++; if ({avl_read, avl_write} !== 2'b00) $display("FAIL rst_strobe got=%b exp=00", {avl_read, avl_write}); else n_pass++;
    n_checks++; if (avl_addr !== 26'h0) $display("FAIL rst_addr got=%h exp=0", avl_addr); else n_pass++;
    n_checks++; if (avl_wdata !== 16'h0) $display("FAIL rst_wdata got=%h exp=0", avl_wdata); else n_pass++;
    n_checks++; if ({wr_ack, v_ack, a_ack} !== 3'b000) $display("FAIL rst_acks got=%b exp=000", {wr_ack, v_ack, a_ack}); else n_pass++;
    n_checks++; if ({v_data, a_data} !== 32'h0) $display("FAIL rst_data got=%h exp=0", {v_data, a_data}); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); else n_pass++;
    n_checks++; if ({stat_wr, stat_v, stat_a} !== 48'h0) $display("FAIL rst_stats got=%h exp=0", {stat_wr, stat_v, stat_a}); else n_pass++;
    repeat (3) @(negedge clk);
    Reset_h = 1'b0;
    @(negedge clk);
    n_checks++; if (avl_read !== 1'b0) $display("FAIL idle_no_strobe got=%b exp=0", avl_read); else n_pass++;
  endtask

  task automatic test_round_robin();
    byte         ev [4];
    logic [15:0] dv [4];
    int          n = 0;
    for (int i = 0; i < 4; i++) begin ev[i] = 0; dv[i] = '0; end
    br_lat = 1; v_addr = 25'h1234; a_addr = 25'h0ABCD;
    v_req = 1; a_req = 1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (v_ack) begin ev[n] = "V"; dv[n] = v_data; n++; end
      else if (a_ack) begin ev[n] = "A"; dv[n] = a_data; n++; end
    end
    v_req = 0; a_req = 0;
    n_checks++; if (n !== 4) $display("FAIL rr_ack_count got=%0d exp=4", n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev[i] !== ((i % 2 == 0) ? "V" : "A") || dv[i] !== ((i % 2 == 0) ? 16'hB791 : 16'h0E68))
        $display("FAIL rr_grant%0d got=%s/%h exp=%s/%h", i, ev[i], dv[i],
                 (i % 2 == 0) ? "V" : "A", (i % 2 == 0) ? 16'hB791 : 16'h0E68);
      else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++; if ({v_data, a_data} !== {16'hB791, 16'h0E68}) $display("FAIL rr_data_hold got=%h exp=b7910e68", {v_data, a_data}); else n_pass++;
  endtask

  task automatic test_write_override();
    bit bad = 0;
    br_lat = 3; wr_override = 1; v_req = 1; v_addr = 25'h100;
    wr_req = 1; wr_addr = 25'h000010; wr_data = 16'hBEEF;
    @(negedge clk);
    n_checks++; if ({avl_write, avl_read} !== 2'b10) $display("FAIL wr_strobe got=%b exp=10", {avl_write, avl_read}); else n_pass++;
    n_checks++; if (avl_addr !== 26'h0000020) $display("FAIL wr_addr got=%h exp=0000020", avl_addr); else n_pass++;
    n_checks++; if (avl_wdata !== 16'hBEEF) $display("FAIL wr_wdata got=%h exp=beef", avl_wdata); else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (avl_write !== 1'b1 || avl_addr !== 26'h20 || avl_wdata !== 16'hBEEF || wr_ack !== 1'b0) bad = 1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL wr_hold got=%b exp=0", bad); else n_pass++;
    @(negedge clk);
    wr_req = 0;
    n_checks++; if ({avl_write, wr_ack} !== 2'b01) $display("FAIL wr_ack_pulse got=%b exp=01", {avl_write, wr_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if (wr_ack !== 1'b0) $display("FAIL wr_ack_width got=%b exp=0", wr_ack); else n_pass++;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (avl_read !== 1'b0 || v_ack !== 1'b0) bad = 1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL wr_video_blocked got=%b exp=0", bad); else n_pass++;
    v_req = 0; wr_override = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    byte         ev [3];
    logic [15:0] dv [3];
    logic [25:0] rd_addr0 = '1;
    bit          seen_rd = 0;
    int          n = 0;
    for (int i = 0; i < 3; i++) begin ev[i] = 0; dv[i] = '0; end
    br_lat = 6; wr_override = 1;
    wr_req = 1; wr_addr = 25'h55; wr_data = 16'h1111;
    @(negedge clk);
    n_checks++; if (avl_write !== 1'b1) $display("FAIL st_wr_grant got=%b exp=1", avl_write); else n_pass++;
    wr_req = 0; wr_override = 0;
    a_req = 1; a_addr = 25'h40; v_req = 1; v_addr = 25'h80;
    for (int c = 0; c < 80 && n < 3; c++) begin
      @(negedge clk);
      if (avl_read && !seen_rd) begin seen_rd = 1; rd_addr0 = avl_addr; end
      if (wr_ack) begin ev[n] = "W"; n++; end
      else if (a_ack) begin ev[n] = "A"; dv[n] = a_data; n++; end
      else if (v_ack) begin ev[n] = "V"; dv[n] = v_data; n++; end
    end
    a_req = 0; v_req = 0;
    n_checks++; if (ev[0] !== "W") $display("FAIL st_wr_complete got=%s exp=W", ev[0]); else n_pass++;
    n_checks++; if (rd_addr0 !== 26'h80) $display("FAIL st_first_read_addr got=%h exp=0000080", rd_addr0); else n_pass++;
    n_checks++; if (ev[1] !== "A" || dv[1] !== 16'hA5E5) $display("FAIL st_forced_audio got=%s/%h exp=A/a5e5", ev[1], dv[1]); else n_pass++;
    n_checks++; if (ev[2] !== "V" || dv[2] !== 16'hA525) $display("FAIL st_then_video got=%s/%h exp=V/a525", ev[2], dv[2]); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit done = 0;
    bit rd_at_ack = 1;
    logic [15:0] d_at_ack = 16'hFFFF;
    logic te_at_ack = 1'b0;
    br_never = 1; a_addr = 25'h2222;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_err_pre got=%b exp=0", timeout_err); else n_pass++;
    a_req = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (a_ack) begin
        done = 1; rd_at_ack = avl_read; d_at_ack = a_data; te_at_ack = timeout_err;
      end else if (avl_read) hi++;
    end
    a_req = 0;
    n_checks++; if (done !== 1'b1) $display("FAIL to_ack_seen got=%b exp=1", done); else n_pass++;
    n_checks++; if (hi !== 16) $display("FAIL to_strobe_cycles got=%0d exp=16", hi); else n_pass++;
    n_checks++; if (rd_at_ack !== 1'b0 || d_at_ack !== 16'h0000) $display("FAIL to_ack_state got=%b/%h exp=0/0000", rd_at_ack, d_at_ack); else n_pass++;
    n_checks++; if (te_at_ack !== 1'b1) $display("FAIL to_err_set got=%b exp=1", te_at_ack); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", timeout_err); else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    bit got = 0;
    bit bad = 0;
    bit done = 0;
    v_addr = 25'h77; v_req = 1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (avl_read) got = 1;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL rm_strobe_up got=%b exp=1", got); else n_pass++;
    @(negedge clk);
    #2 Reset_h = 1'b1;
    #1;
    n_checks++; if ({avl_read, avl_write} !== 2'b00) $display("FAIL rm_strobe_drop got=%b exp=00", {avl_read, avl_write}); else n_pass++;
    n_checks++; if (avl_addr !== 26'h0 || {v_data, a_data} !== 32'h0) $display("FAIL rm_regs got=%h/%h exp=0/0", avl_addr, {v_data, a_data}); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rm_err_clear got=%b exp=0", timeout_err); else n_pass++;
    n_checks++; if ({stat_wr, stat_v, stat_a} !== 48'h0) $display("FAIL rm_stats got=%h exp=0", {stat_wr, stat_v, stat_a}); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (v_ack || a_ack || wr_ack || avl_read) bad = 1;
    end
    Reset_h = 1'b0; br_never = 0; br_lat = 1;
    n_checks++; if (bad !== 1'b0) $display("FAIL rm_no_ack got=%b exp=0", bad); else n_pass++;
    @(negedge clk);
    n_checks++; if (avl_read !== 1'b1 || avl_addr !== 26'hEE) $display("FAIL rm_regrant got=%b/%h exp=1/00000ee", avl_read, avl_addr); else n_pass++;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (v_ack) done = 1;
    end
    v_req = 0;
    n_checks++; if (done !== 1'b1 || v_data !== 16'hA5D2) $display("FAIL rm_post_read got=%b/%h exp=1/a5d2", done, v_data); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_override();
    test_starvation();
    test_timeout();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avl_port_scheduler.md
AVL_PORT_SCHEDULER -- requirements
Module: avl_port_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 64: audio-wait cycles before forced audio grant.
REQ-002 SHALL have parameter TIMEOUT, default 1024: cycles in ISSUE before abort.
REQ-003 SHALL have port MAX10_CLK1_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset_h  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_override  in  1  SD-load phase; only writes are served.
REQ-006 SHALL have port wr_req / wr_addr / wr_data  in  1/25/16  SD loader write request, word address, data.
REQ-007 SHALL have port wr_ack  out  1  one-cycle write-complete pulse.
REQ-008 SHALL have port v_req / v_addr  in  1/25  video read request, word address.
REQ-009 SHALL have port v_ack / v_data  out  1/16  video ack pulse, read data.
REQ-010 SHALL have port a_req / a_addr  in  1/25  audio read request, word address.
REQ-011 SHALL have port a_ack / a_data  out  1/16  audio ack pulse, read data.
REQ-012 SHALL have port avl_addr / avl_read / avl_write / avl_wdata  out  26/1/1/16  Avalon bridge master.
REQ-013 SHALL have port avl_rddata / avl_ack  in  16/1  Avalon bridge read data, acknowledge.
REQ-014 SHALL have port timeout_err  out  1  sticky bridge-timeout flag.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; RESP lasts exactly one cycle.
REQ-016 In IDLE with wr_override=1, SHALL grant only wr_req; v_req/a_req wait.
REQ-017 In IDLE with wr_override=0, SHALL grant in order: audio if starve count >= STARVE_LIMIT, else round-robin v/a (opposite of last read grant; video first after reset), else wr_req.
REQ-018 On grant, SHALL register avl_addr = {granted addr, 1'b0} (byte address), the strobe, and avl_wdata; strobe asserted the cycle after grant.
REQ-019 SHALL hold strobe, address and data constant through ISSUE until the cycle avl_ack=1.
REQ-020 On avl_ack in cycle N, SHALL drop strobe at N+1, pulse the granted requester's ack at N+1 and, for reads, register avl_rddata into that requester's data at N+1.
REQ-021 v_data/a_data SHALL hold their value until the next ack to that requester.
REQ-022 Starve counter SHALL count cycles with a_req=1 and not granted, saturate at STARVE_LIMIT, and clear on audio grant.
REQ-023 If ISSUE reaches TIMEOUT cycles without avl_ack, SHALL drop strobe, pulse the requester ack with data 16'h0000, set timeout_err, then RESP.
REQ-024 wr_override toggling mid-transaction SHALL NOT abort the transaction; the new mode applies at the next IDLE.
REQ-025 A request deasserted before grant SHALL be ignored; a request still high in IDLE after its RESP SHALL be a new transaction.

Reset
REQ-026 Reset_h SHALL force immediately: state IDLE, avl_read=avl_write=0, avl_addr=0, avl_wdata=0, all acks 0, v_data=a_data=0, starve count 0, last-grant=audio, timeout_err=0.
REQ-027 Reset mid-ISSUE SHALL abandon the transaction without issuing an ack.

Configuration
REQ-028 With AVL_SCHED_STATS_EN defined, SHALL add outputs stat_wr, stat_v, stat_a (16 bits each), saturating grant counters cleared by reset.
REQ-029 Without AVL_SCHED_STATS_EN, those ports SHALL exist, tied to 16'h0000, with no counter logic.

Structure
REQ-030 Package avl_sched_pkg SHALL hold the state enum, the requester-id enum {REQ_NONE, REQ_WR, REQ_V, REQ_A}, and widths WORD_ADDR_W=25, AVL_ADDR_W=26, DATA_W=16.
REQ-031 The starvation counter SHALL be the sub-module avl_sched_starve_ctr.

Verification
REQ-032 Override=1, wr_req addr 0x000010 data 0xBEEF, bridge ack after 3 cycles -> avl_write=1 with avl_addr 0x0000020, wr_ack pulse one cycle after ack.
REQ-033 Override=0, v_req and a_req held continuously, bridge acks after 1 cycle -> grants alternate V,A,V,A; each ack carries matching data.
REQ-034 STARVE_LIMIT=4, a_req held, bridge acks video-only in round-robin off-turns -> audio granted no later than once the count reaches 4.
REQ-035 TIMEOUT=16, bridge never acks a_req -> strobe drops after 16 ISSUE cycles, a_ack pulse with a_data=0x0000, timeout_err=1 until reset.
REQ-036 Reset_h asserted mid-ISSUE -> strobes 0 same cycle, no ack pulse, FSM IDLE; with AVL_SCHED_STATS_EN, stat_* = 0.
